truth_table_sweeper: RTL and testbench
======================================

TRUTH_TABLE_SWEEPER -- requirements
Module: truth_table_sweeper

Interface
REQ-001 Parameter SETTLE, default 1, number of cycles each input vector is held before the response is sampled (legal 1..15).
REQ-002 Parameter EXPECTED, default 16'hAC3C, golden truth table with bit i = expected f for vector i (minterms 2,3,4,5,A,B,D,F).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 start  input  1  request a full 16-vector sweep; sampled only in IDLE and DONE.
REQ-006 s_in  input  1  response of the downstream combinational function under test.
REQ-007 a, b, c, d  output  1 each  stimulus vector to the function; a = idx[3] (MSB) ... d = idx[0].
REQ-008 busy  output  1  high in DRIVE and SAMPLE.
REQ-009 done  output  1  high while in DONE (level, not pulse).
REQ-010 table  output  16  captured responses; bit i = s_in sampled for vector i.
REQ-011 ones  output  5  population count of table, range 0..16.
REQ-012 pass  output  1  table == EXPECTED; valid only while done=1, else 0.
REQ-013 mismatch  output  16  table XOR EXPECTED while done=1, else 0.

Function
REQ-014 The FSM SHALL have states IDLE, DRIVE, SAMPLE, DONE, encoded in 2 bits.
REQ-015 The block SHALL hold a 4-bit vector index idx and a 4-bit settle counter wcnt.
REQ-016 In IDLE with start=1, the FSM SHALL go to DRIVE with idx=0, wcnt=0, table=0.
REQ-017 In IDLE with start=0, the FSM SHALL remain in IDLE with all registers unchanged.
REQ-018 In DRIVE, wcnt SHALL increment each cycle, and the FSM SHALL go to SAMPLE when wcnt==SETTLE-1.
REQ-019 In SAMPLE, table[idx] SHALL load s_in and wcnt SHALL clear.
REQ-020 From SAMPLE with idx<15, idx SHALL increment and the FSM SHALL return to DRIVE.
REQ-021 From SAMPLE with idx==15, the FSM SHALL go to DONE and idx SHALL hold at 15, with no wrap to 0.
REQ-022 Outputs a..d SHALL equal idx bits in every state, so they are stable for all SETTLE+1 cycles of each vector.
REQ-023 From the start-sampling edge to the first cycle with done=1, latency SHALL be exactly 16*(SETTLE+1) cycles (32 with default SETTLE).
REQ-024 The start input SHALL be ignored while busy=1.
REQ-025 In DONE with start=1, the block SHALL restart as in REQ-016 on the same edge, and done SHALL fall the following cycle.
REQ-026 In DONE with start=0, the block SHALL hold table, idx and done indefinitely.
REQ-027 The ones output SHALL be computed combinationally from table and SHALL be valid in all states.
REQ-028 Each table bit SHALL be written exactly once per sweep and SHALL never be written outside SAMPLE.

Reset
REQ-029 With reset=1 at a rising edge, the block SHALL enter IDLE with idx=0, wcnt=0 and table=0, and the outputs SHALL read a=b=c=d=0, busy=0, done=0, ones=0, pass=0, mismatch=0.
REQ-030 Reset SHALL take priority over start and over any state, including a sweep in progress, which is abandoned without completing.
REQ-031 After reset deasserts, no sweep SHALL begin until start is sampled high.

Verification
REQ-032 Reference SoP connected, SETTLE=1; reset, start pulse 1 cycle -> a..d walk 0000..1111, 2 cycles each; done at cycle 32; table=16'hAC3C, ones=8, pass=1, mismatch=0.
REQ-033 s_in tied to 0 -> table=0000, ones=0, pass=0, mismatch=AC3C; s_in tied to 1 -> table=FFFF, ones=16, mismatch=53C3.
REQ-034 Reset asserted when idx=7 in DRIVE -> next cycle IDLE, table=0, a..d=0000, busy=0; start again -> full 32-cycle sweep with correct result.
REQ-035 start held high through the entire sweep -> no restart while busy; at DONE, immediate restart (done high for exactly 1 cycle), table cleared.
REQ-036 SETTLE=3 -> each vector held 4 cycles; done at cycle 64; table=AC3C.
REQ-037 Function with minterm F inverted -> table=2C3C, pass=0, mismatch=8000, ones=7.

Source files
------------

// File: rtl/truth_table_sweeper_if.sv
// Bundle of the sweeper's control, stimulus and result signals.
// The master side (test controller) issues start and returns the response of
// the function under test; the slave side (the sweeper) drives the vector
// and reports the captured truth table.
interface truth_table_sweeper_if;
    logic        start_i;     // request a full 16-vector sweep
    logic        s_in_i;      // response of the function under test
    logic        a_o;         // vector bit 3 (MSB)
    logic        b_o;         // vector bit 2
    logic        c_o;         // vector bit 1
    logic        d_o;         // vector bit 0 (LSB)
    logic        busy_o;      // sweep in progress
    logic        done_o;      // sweep finished, results valid
    logic [15:0] table_o;     // captured responses, bit i = vector i
    logic [4:0]  ones_o;      // population count of table_o
    logic        pass_o;      // table matches golden table (only while done)
    logic [15:0] mismatch_o;  // table XOR golden table (only while done)

    modport master (
        output start_i,
        output s_in_i,
        input  a_o,
        input  b_o,
        input  c_o,
        input  d_o,
        input  busy_o,
        input  done_o,
        input  table_o,
        input  ones_o,
        input  pass_o,
        input  mismatch_o
    );

    modport slave (
        input  start_i,
        input  s_in_i,
        output a_o,
        output b_o,
        output c_o,
        output d_o,
        output busy_o,
        output done_o,
        output table_o,
        output ones_o,
        output pass_o,
        output mismatch_o
    );
endinterface

// File: rtl/truth_table_sweeper.sv
// Truth-table sweeper: walks a 4-input combinational function through all 16
// input vectors, holds each vector for SETTLE cycles, samples the response on
// one extra cycle, and compares the captured table with a golden table.
// SETTLE must lie in 1..15 so the settle count fits the 4-bit counter.
module truth_table_sweeper #(
    parameter int unsigned SETTLE   = 1,
    parameter logic [15:0] EXPECTED = 16'hAC3C
) (
    input logic                  clk,
    input logic                  reset,
    truth_table_sweeper_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DRIVE  = 2'd1,
        SAMPLE = 2'd2,
        DONE   = 2'd3
    } state_t;

    // Last settle count before the response is sampled.
    localparam logic [3:0] LAST_WAIT = 4'(SETTLE - 1);

    state_t      state_q, state_d;
    logic [3:0]  idx_q,   idx_d;
    logic [3:0]  wcnt_q,  wcnt_d;
    logic [15:0] table_q, table_d;
    logic        busy_q,  busy_d;
    logic        done_q,  done_d;

    // Number of ones in a 16-bit table, 0..16.
    function automatic logic [4:0] popcount16(input logic [15:0] v);
        logic [4:0] n;
        n = '0;
        for (int i = 0; i < 16; i++) begin
            n = n + 5'(v[i]);
        end
        return n;
    endfunction

    // Next-state logic: sweep sequencing, settle counting and table capture.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        wcnt_d  = wcnt_q;
        table_d = table_q;
        busy_d  = busy_q;
        done_d  = done_q;

        case (state_q)
            IDLE, DONE: begin
                // A new sweep always starts from vector 0 with a clean table;
                // without start both states simply hold.
                if (bus.start_i) begin
                    state_d = DRIVE;
                    idx_d   = 4'd0;
                    wcnt_d  = 4'd0;
                    table_d = 16'h0000;
                    busy_d  = 1'b1;
                    done_d  = 1'b0;
                end
            end

            DRIVE: begin
                wcnt_d = wcnt_q + 4'd1;
                if (wcnt_q == LAST_WAIT) begin
                    state_d = SAMPLE;
                end
            end

            SAMPLE: begin
                // Only place the table is written; each index is visited once.
                table_d[idx_q] = bus.s_in_i;
                wcnt_d         = 4'd0;
                if (idx_q == 4'd15) begin
                    // Index stays at 15 so the last vector remains applied.
                    state_d = DONE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end else begin
                    idx_d   = idx_q + 4'd1;
                    state_d = DRIVE;
                end
            end
        endcase
    end

    // State registers; reset abandons any sweep and clears the table.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            idx_q   <= 4'd0;
            wcnt_q  <= 4'd0;
            table_q <= 16'h0000;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            wcnt_q  <= wcnt_d;
            table_q <= table_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    // Vector bits come straight from the index register, so they are stable
    // for the whole settle-plus-sample window of each vector.
    assign bus.a_o = idx_q[3];
    assign bus.b_o = idx_q[2];
    assign bus.c_o = idx_q[1];
    assign bus.d_o = idx_q[0];

    assign bus.busy_o  = busy_q;
    assign bus.done_o  = done_q;
    assign bus.table_o = table_q;
    assign bus.ones_o  = popcount16(table_q);

    // Comparison results are only meaningful once the table is complete.
    assign bus.pass_o     = done_q & (table_q == EXPECTED);
    assign bus.mismatch_o = done_q ? (table_q ^ EXPECTED) : 16'h0000;

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Scoreboard bench for truth_table_sweeper: stimulus pushes one expected sweep
// per start, a monitor follows the vector walk and checks results on done.
module tb_truth_table_sweeper;

    localparam logic [15:0] GOLD = 16'hAC3C;

    logic clk = 1'b0;
    logic reset;
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    truth_table_sweeper_if if0();
    truth_table_sweeper_if if1();

    truth_table_sweeper #(.SETTLE(1), .EXPECTED(GOLD)) dut0 (
        .clk   (clk),
        .reset (reset),
        .bus   (if0)
    );

    truth_table_sweeper #(.SETTLE(3), .EXPECTED(GOLD)) dut1 (
        .clk   (clk),
        .reset (reset),
        .bus   (if1)
    );

    // Function under test for each DUT, modelled as a lookup table.
    logic [15:0] func_tt [2];
    assign if0.s_in_i = func_tt[0][{if0.a_o, if0.b_o, if0.c_o, if0.d_o}];
    assign if1.s_in_i = func_tt[1][{if1.a_o, if1.b_o, if1.c_o, if1.d_o}];

    logic [3:0]  vec_w  [2];
    logic        busy_w [2];
    logic        done_w [2];
    logic        pass_w [2];
    logic [4:0]  ones_w [2];
    logic [15:0] tbl_w  [2];
    logic [15:0] mm_w   [2];

    assign vec_w[0]  = {if0.a_o, if0.b_o, if0.c_o, if0.d_o};
    assign vec_w[1]  = {if1.a_o, if1.b_o, if1.c_o, if1.d_o};
    assign busy_w[0] = if0.busy_o;
    assign busy_w[1] = if1.busy_o;
    assign done_w[0] = if0.done_o;
    assign done_w[1] = if1.done_o;
    assign pass_w[0] = if0.pass_o;
    assign pass_w[1] = if1.pass_o;
    assign ones_w[0] = if0.ones_o;
    assign ones_w[1] = if1.ones_o;
    assign tbl_w[0]  = if0.table_o;
    assign tbl_w[1]  = if1.table_o;
    assign mm_w[0]   = if0.mismatch_o;
    assign mm_w[1]   = if1.mismatch_o;

    typedef struct {
        int          dut;
        int          start_cyc;   // clock edge that samples start
        logic [15:0] tt;          // function table applied during the sweep
    } exp_t;

    exp_t exp_q[$];

    function automatic int settle_of(input int d);
        return (d == 0) ? 1 : 3;
    endfunction

    function automatic int pop16(input logic [15:0] v);
        int n;
        n = 0;
        for (int i = 0; i < 16; i++) if (v[i]) n++;
        return n;
    endfunction

    // Reference function: minterms 2,3,4,5,A,B,D,F as a sum of products.
    function automatic logic [15:0] sop_tt();
        logic [15:0] t;
        logic [3:0]  v;
        for (int i = 0; i < 16; i++) begin
            v    = 4'(i);
            t[i] = (~v[2] & v[1]) | (~v[3] & v[2] & ~v[1]) | (v[3] & v[2] & v[0]);
        end
        return t;
    endfunction

    function automatic int n_pending(input int d);
        int n;
        n = 0;
        for (int j = 0; j < exp_q.size(); j++) if (exp_q[j].dut == d) n++;
        return n;
    endfunction

    task automatic purge(input int d);
        for (int j = exp_q.size() - 1; j >= 0; j--) begin
            if (exp_q[j].dut == d) exp_q.delete(j);
        end
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    // Monitor: follows the walk of the pending sweep, checks results on done.
    logic        done_prev [2];
    logic        walk_bad  [2];
    int          walk_k    [2];
    logic [31:0] walk_act  [2];
    logic [31:0] walk_req  [2];

    initial begin : monitor
        int          fi, k, per, len, nb, vexp;
        logic [15:0] part;
        logic [31:0] act_st, req_st;
        exp_t        e;
        for (int d = 0; d < 2; d++) begin
            done_prev[d] = 1'b0;
            walk_bad[d]  = 1'b0;
            walk_k[d]    = 0;
            walk_act[d]  = '0;
            walk_req[d]  = '0;
        end
        forever begin
            @(negedge clk);
            for (int d = 0; d < 2; d++) begin
                fi = -1;
                k  = 0;
                for (int j = 0; j < exp_q.size(); j++) begin
                    if (fi < 0 && exp_q[j].dut == d) fi = j;
                end
                per = settle_of(d) + 1;
                len = 16 * per;
                if (fi < 0) begin
                    walk_bad[d] = 1'b0;
                end else begin
                    e = exp_q[fi];
                    k = cyc - e.start_cyc;
                    if (k >= 0 && k <= len) begin
                        nb   = k / per;
                        vexp = (nb > 15) ? 15 : nb;
                        part = (nb >= 16) ? e.tt : (e.tt & 16'((32'd1 << nb) - 32'd1));
                        req_st = {3'b000, 4'(vexp), k < len, k == len,
                                  (k == len) && (e.tt == GOLD), 5'(pop16(part)), part,
                                  (k == len) && (e.tt != GOLD)};
                        act_st = {3'b000, vec_w[d], busy_w[d], done_w[d], pass_w[d],
                                  ones_w[d], tbl_w[d], |mm_w[d]};
                        if (act_st !== req_st && !walk_bad[d]) begin
                            walk_bad[d] = 1'b1;
                            walk_k[d]   = k;
                            walk_act[d] = act_st;
                            walk_req[d] = req_st;
                        end
                    end
                end
                if (done_w[d] && !done_prev[d]) begin
                    if (fi < 0) begin
                        chk($sformatf("dut%0d done_without_sweep", d), 32'(fi >= 0), 32'd1);
                    end else begin
                        chk($sformatf("dut%0d latency", d), 32'(k), 32'(len));
                        chk($sformatf("dut%0d table", d), 32'(tbl_w[d]), 32'(e.tt));
                        chk($sformatf("dut%0d ones", d), 32'(ones_w[d]), 32'(pop16(e.tt)));
                        chk($sformatf("dut%0d pass", d), 32'(pass_w[d]), 32'(e.tt == GOLD));
                        chk($sformatf("dut%0d mismatch", d), 32'(mm_w[d]), 32'(e.tt ^ GOLD));
                        n_cmp++;
                        if (walk_bad[d]) begin
                            n_bad++;
                            $display("FAIL dut%0d walk at k=%0d: got %h, required %h (vec,busy,done,pass,ones,table,mm)",
                                     d, walk_k[d], walk_act[d], walk_req[d]);
                        end
                        exp_q.delete(fi);
                    end
                    walk_bad[d] = 1'b0;
                end
                done_prev[d] = done_w[d];
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic set_start(input int d, input logic v);
        if (d == 0) if0.start_i = v;
        else        if1.start_i = v;
    endtask

    task automatic start_sweep(input int d, input logic [15:0] tt, input int width);
        exp_t e;
        func_tt[d]  = tt;
        e.dut       = d;
        e.start_cyc = cyc + 1;
        e.tt        = tt;
        exp_q.push_back(e);
        set_start(d, 1'b1);
        tick(width);
        set_start(d, 1'b0);
    endtask

    task automatic wait_drain(input int d, input int budget);
        int i;
        i = 0;
        while (n_pending(d) != 0 && i < budget) begin
            tick(1);
            i++;
        end
        if (n_pending(d) != 0) begin
            chk($sformatf("dut%0d sweep_timeout", d), 32'(n_pending(d)), 32'd0);
            purge(d);
        end
    endtask

    task automatic check_hold(input int d, input logic [15:0] tt);
        tick(int'($urandom_range(3, 12)));
        chk($sformatf("dut%0d hold_done", d), 32'(done_w[d]), 32'd1);
        chk($sformatf("dut%0d hold_busy", d), 32'(busy_w[d]), 32'd0);
        chk($sformatf("dut%0d hold_vec", d), 32'(vec_w[d]), 32'd15);
        chk($sformatf("dut%0d hold_table", d), 32'(tbl_w[d]), 32'(tt));
    endtask

    task automatic check_idle(input int d, input string tag);
        chk($sformatf("dut%0d %s_vec", d, tag), 32'(vec_w[d]), 32'd0);
        chk($sformatf("dut%0d %s_busy", d, tag), 32'(busy_w[d]), 32'd0);
        chk($sformatf("dut%0d %s_done", d, tag), 32'(done_w[d]), 32'd0);
        chk($sformatf("dut%0d %s_table", d, tag), 32'(tbl_w[d]), 32'd0);
        chk($sformatf("dut%0d %s_ones", d, tag), 32'(ones_w[d]), 32'd0);
        chk($sformatf("dut%0d %s_pass", d, tag), 32'(pass_w[d]), 32'd0);
        chk($sformatf("dut%0d %s_mismatch", d, tag), 32'(mm_w[d]), 32'd0);
    endtask

    task automatic full_sweep(input int d, input logic [15:0] tt, input int width);
        start_sweep(d, tt, width);
        wait_drain(d, 16 * (settle_of(d) + 1) + 40);
        check_hold(d, tt);
    endtask

    initial begin : stimulus
        int          c0;
        exp_t        e;
        logic [15:0] tt;
        reset       = 1'b1;
        if0.start_i = 1'b0;
        if1.start_i = 1'b0;
        func_tt[0]  = 16'h0000;
        func_tt[1]  = 16'h0000;
        tick(3);
        reset = 1'b0;
        check_idle(0, "reset");
        check_idle(1, "reset");

        // Idle with start low: nothing happens.
        tick(5);
        check_idle(0, "idle");

        // Reference function, tied-low, tied-high and minterm F inverted.
        full_sweep(0, sop_tt(), 1);
        full_sweep(0, 16'h0000, 1);
        full_sweep(0, 16'hFFFF, 1);
        full_sweep(0, GOLD ^ 16'h8000, 1);

        // Reset while vector 7 is being driven abandons the sweep.
        start_sweep(0, sop_tt(), 1);
        tick(14);
        chk("dut0 pre_reset_vec", 32'(vec_w[0]), 32'd7);
        chk("dut0 pre_reset_busy", 32'(busy_w[0]), 32'd1);
        reset = 1'b1;
        purge(0);
        tick(1);
        reset = 1'b0;
        check_idle(0, "abort");
        tick(6);
        chk("dut0 post_abort_busy", 32'(busy_w[0]), 32'd0);
        chk("dut0 post_abort_vec", 32'(vec_w[0]), 32'd0);
        full_sweep(0, sop_tt(), 1);

        // Start held through a whole sweep: ignored while busy, immediate
        // restart from done; the second sweep is released midway.
        tt          = sop_tt();
        func_tt[0]  = tt;
        c0          = cyc + 1;
        e.dut       = 0;
        e.tt        = tt;
        e.start_cyc = c0;
        exp_q.push_back(e);
        e.start_cyc = c0 + 33;
        exp_q.push_back(e);
        set_start(0, 1'b1);
        tick(46);
        set_start(0, 1'b0);
        wait_drain(0, 120);
        check_hold(0, tt);

        // Random function tables with random start pulse widths.
        for (int n = 0; n < 8; n++) begin
            full_sweep(0, 16'($urandom), int'($urandom_range(1, 25)));
            tick(int'($urandom_range(0, 4)));
        end

        // Longer settle time.
        full_sweep(1, sop_tt(), 1);
        full_sweep(1, 16'($urandom), int'($urandom_range(1, 25)));
        full_sweep(1, GOLD ^ 16'h8000, 1);

        tick(2);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation time limit reached, cmp=%0d bad=%0d", n_cmp, n_bad);
        $fatal(1, "watchdog");
    end

endmodule
